// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - BCD time-of-day core with key-driven set mode
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   tick_1hz   in   one-cycle pulse per second
//   timeout    in   one-cycle pulse after key inactivity, leaves set mode
//   key[4:0]   in   one-cycle key pulses: 0 mode/next, 1 up, 2 down, 3 exit, 4 clear sec
//   hour_bcd   out  hours, two BCD digits
//   min_bcd    out  minutes, two BCD digits
//   sec_bcd    out  seconds, two BCD digits
//   pm         out  PM indicator (always 0 in the 24 h build)
//   set_mode   out  high in any SET state
//   set_field  out  edited field: 0 none, 1 hour, 2 min, 3 sec
//   field_on   out  blink enable for the edited field
//   day_pulse  out  one-cycle pulse on the midnight rollover
//
// Build option: define TIME_12H_EN for a 12 h display (12,01..11 plus pm).
module time_keeper (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       timeout,
   input  logic [4:0] key,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       pm,
   output logic       set_mode,
   output logic [1:0] set_field,
   output logic       field_on,
   output logic       day_pulse
);

   typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} state_t;

`ifdef TIME_12H_EN
   localparam logic [7:0] HOUR_RST = 8'h12;
`else
   localparam logic [7:0] HOUR_RST = 8'h00;
`endif

   state_t     state_q, state_d;
   logic [7:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
   logic       pm_q, pm_d, set_mode_q, set_mode_d, field_on_q, field_on_d;
   logic       day_pulse_q, day_pulse_d;
   logic [1:0] set_field_q, set_field_d;

   // {pm, hour} after one step up / down, and whether a step up crosses midnight
   logic [8:0] hour_inc, hour_dec;
   logic       at_midnight;

   // Key priority: lowest index wins, the rest are dropped
   logic k_mode, k_up, k_dn, k_exit, k_clr;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
      logic [7:0] r;
      if (v == top)              r = 8'h00;
      else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
      else                       r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
      logic [7:0] r;
      if (v == 8'h00)            r = top;
      else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
      else                       r = {v[7:4], v[3:0] - 4'd1};
      return r;
   endfunction

   always_comb begin
`ifdef TIME_12H_EN
      // 12 is the first hour of each half; pm flips when 11 rolls into 12
      if (hour_q == 8'h12)      hour_inc = {pm_q, 8'h01};
      else if (hour_q == 8'h11) hour_inc = {~pm_q, 8'h12};
      else                      hour_inc = {pm_q, bcd_inc(hour_q, 8'h12)};
      if (hour_q == 8'h12)      hour_dec = {~pm_q, 8'h11};
      else if (hour_q == 8'h01) hour_dec = {pm_q, 8'h12};
      else                      hour_dec = {pm_q, bcd_dec(hour_q, 8'h12)};
      at_midnight = pm_q && (hour_q == 8'h11);
`else
      hour_inc    = {1'b0, bcd_inc(hour_q, 8'h23)};
      hour_dec    = {1'b0, bcd_dec(hour_q, 8'h23)};
      at_midnight = (hour_q == 8'h23);
`endif
   end

   always_comb begin
      k_mode = key[0];
      k_up   = key[1] & ~key[0];
      k_dn   = key[2] & ~|key[1:0];
      k_exit = key[3] & ~|key[2:0];
      k_clr  = key[4] & ~|key[3:0];

      state_d     = state_q;
      hour_d      = hour_q;
      min_d       = min_q;
      sec_d       = sec_q;
      pm_d        = pm_q;
      field_on_d  = field_on_q;
      day_pulse_d = 1'b0;

      if (state_q == RUN) begin
         field_on_d = 1'b1;
         // A clear in the same cycle as a tick suppresses the tick and its carries
         if (k_clr) begin
            sec_d = 8'h00;
         end else if (tick_1hz) begin
            sec_d = bcd_inc(sec_q, 8'h59);
            if (sec_q == 8'h59) begin
               min_d = bcd_inc(min_q, 8'h59);
               if (min_q == 8'h59) begin
                  {pm_d, hour_d} = hour_inc;
                  day_pulse_d    = at_midnight;
               end
            end
         end
         if (k_mode) state_d = SET_H;
      end else if (timeout) begin
         // Timeout overrides every key in this cycle
         state_d    = RUN;
         field_on_d = 1'b1;
      end else begin
         if (tick_1hz) field_on_d = ~field_on_q;
         if (k_mode) begin
            case (state_q)
               SET_H:   state_d = SET_M;
               SET_M:   state_d = SET_S;
               default: state_d = RUN;
            endcase
            field_on_d = 1'b1;
         end else if (k_exit) begin
            state_d    = RUN;
            field_on_d = 1'b1;
         end else if (k_up) begin
            case (state_q)
               SET_H:   {pm_d, hour_d} = hour_inc;
               SET_M:   min_d = bcd_inc(min_q, 8'h59);
               default: sec_d = bcd_inc(sec_q, 8'h59);
            endcase
         end else if (k_dn) begin
            case (state_q)
               SET_H:   {pm_d, hour_d} = hour_dec;
               SET_M:   min_d = bcd_dec(min_q, 8'h59);
               default: sec_d = bcd_dec(sec_q, 8'h59);
            endcase
         end else if (k_clr) begin
            sec_d = 8'h00;
         end
      end

      set_mode_d  = (state_d != RUN);
      set_field_d = state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         hour_q      <= HOUR_RST;
         min_q       <= 8'h00;
         sec_q       <= 8'h00;
         pm_q        <= 1'b0;
         set_mode_q  <= 1'b0;
         set_field_q <= 2'd0;
         field_on_q  <= 1'b1;
         day_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hour_q      <= hour_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         pm_q        <= pm_d;
         set_mode_q  <= set_mode_d;
         set_field_q <= set_field_d;
         field_on_q  <= field_on_d;
         day_pulse_q <= day_pulse_d;
      end
   end

   assign hour_bcd  = hour_q;
   assign min_bcd   = min_q;
   assign sec_bcd   = sec_q;
   assign pm        = pm_q;
   assign set_mode  = set_mode_q;
   assign set_field = set_field_q;
   assign field_on  = field_on_q;
   assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - self-checking bench for time_keeper
//
// Drives directed scenarios and random stimulus; expected values come from a
// seconds/fields model kept in the bench. Honours TIME_12H_EN like the design.
module tb_time_keeper;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_1hz = 1'b0;
   logic       timeout = 1'b0;
   logic [4:0] key = 5'd0;
   logic [7:0] hour_bcd, min_bcd, sec_bcd;
   logic       pm, set_mode, field_on, day_pulse;
   logic [1:0] set_field;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: 24 h integer time, state 0 RUN / 1 hour / 2 min / 3 sec
   int mh, mm, ms, mstate;
   bit mfon, mday;

   logic [29:0] dut_vec;
   assign dut_vec = {hour_bcd, min_bcd, sec_bcd, pm, set_mode, set_field, field_on, day_pulse};

   time_keeper dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .timeout(timeout), .key(key),
      .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .pm(pm),
      .set_mode(set_mode), .set_field(set_field), .field_on(field_on), .day_pulse(day_pulse)
   );

   always #10 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic logic [7:0] exp_hour(input int h);
`ifdef TIME_12H_EN
      return to_bcd((h % 12 == 0) ? 12 : h % 12);
`else
      return to_bcd(h);
`endif
   endfunction

   function automatic logic exp_pm(input int h);
`ifdef TIME_12H_EN
      return (h >= 12);
`else
      return (h < 0);
`endif
   endfunction

   function automatic logic [29:0] exp_vec();
      return {exp_hour(mh), to_bcd(mm), to_bcd(ms), exp_pm(mh), (mstate != 0),
              2'(mstate), mfon, mday};
   endfunction

   task automatic bump(input int d);
      if (mstate == 1)      mh = (mh + d + 24) % 24;
      else if (mstate == 2) mm = (mm + d + 60) % 60;
      else                  ms = (ms + d + 60) % 60;
   endtask

   task automatic model_step(input bit r, input bit t, input bit to, input logic [4:0] k);
      int sel, tot;
      if (r) begin
         mh = 0; mm = 0; ms = 0; mstate = 0; mfon = 1; mday = 0;
         return;
      end
      sel = -1;
      for (int i = 4; i >= 0; i--) if (k[i]) sel = i;
      mday = 0;
      if (mstate == 0) begin
         mfon = 1;
         if (sel == 4) ms = 0;
         else if (t) begin
            tot = mh * 3600 + mm * 60 + ms + 1;
            if (tot == 86400) begin tot = 0; mday = 1; end
            mh = tot / 3600; mm = (tot / 60) % 60; ms = tot % 60;
         end
         if (sel == 0) mstate = 1;
      end else if (to) begin
         mstate = 0; mfon = 1;
      end else begin
         if (t) mfon = !mfon;
         case (sel)
            0: begin mstate = (mstate + 1) % 4; mfon = 1; end
            1: bump(1);
            2: bump(-1);
            3: begin mstate = 0; mfon = 1; end
            4: ms = 0;
            default: ;
         endcase
      end
   endtask

   task automatic step(input bit r, input bit t, input bit to, input logic [4:0] k);
      rst = r; tick_1hz = t; timeout = to; key = k;
      model_step(r, t, to, k);
      @(posedge clk);
      #1;
      rst = 1'b0; tick_1hz = 1'b0; timeout = 1'b0; key = 5'd0;
   endtask

   // Walk the fields up with key[1] until the model shows the target; ends in RUN
   task automatic set_time(input int h, input int m, input int s);
      step(0, 0, 0, 5'b00001);
      while (mh != h) step(0, 0, 0, 5'b00010);
      step(0, 0, 0, 5'b00001);
      while (mm != m) step(0, 0, 0, 5'b00010);
      step(0, 0, 0, 5'b00001);
      while (ms != s) step(0, 0, 0, 5'b00010);
      step(0, 0, 0, 5'b00001);
   endtask

   task automatic test_reset();
      step(1, 0, 0, 5'd0);
      n_checks++;
      if (hour_bcd !== exp_hour(0)) begin
         n_fail++; $display("FAIL reset_hour: got %h want %h", hour_bcd, exp_hour(0));
      end
      n_checks++;
      if ({min_bcd, sec_bcd} !== 16'h0000) begin
         n_fail++; $display("FAIL reset_min_sec: got %h want 0000", {min_bcd, sec_bcd});
      end
      n_checks++;
      if ({pm, set_mode, set_field, field_on, day_pulse} !== 6'b000010) begin
         n_fail++; $display("FAIL reset_flags: got %b want 000010",
                            {pm, set_mode, set_field, field_on, day_pulse});
      end
      // Reset in the middle of set mode with every input active
      step(0, 0, 0, 5'b00001);
      step(0, 0, 0, 5'b00010);
      step(1, 1, 1, 5'b11111);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
         n_fail++; $display("FAIL reset_mid_op: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_count_minute();
      step(1, 0, 0, 5'd0);
      for (int i = 1; i <= 60; i++) begin
         step(0, 1, 0, 5'd0);
         n_checks++;
         if (sec_bcd !== to_bcd(i % 60) || day_pulse !== 1'b0) begin
            n_fail++; $display("FAIL count_sec[%0d]: got %h/%b want %h/0", i, sec_bcd, day_pulse, to_bcd(i % 60));
         end
      end
      n_checks++;
      if ({hour_bcd, min_bcd} !== {exp_hour(0), 8'h01}) begin
         n_fail++; $display("FAIL count_min: got %h want %h01", {hour_bcd, min_bcd}, exp_hour(0));
      end
   endtask

   task automatic test_midnight();
      step(1, 0, 0, 5'd0);
      set_time(23, 59, 58);
      step(0, 1, 0, 5'd0);
      n_checks++;
      if ({hour_bcd, min_bcd, sec_bcd, day_pulse} !== {exp_hour(23), 8'h59, 8'h59, 1'b0}) begin
         n_fail++; $display("FAIL midnight_pre: got %h %h %h %b", hour_bcd, min_bcd, sec_bcd, day_pulse);
      end
      step(0, 1, 0, 5'd0);
      n_checks++;
      if ({hour_bcd, min_bcd, sec_bcd, pm, day_pulse} !== {exp_hour(0), 16'h0000, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL midnight_roll: got %h %h %h pm=%b dp=%b want %h 00 00 pm=0 dp=1",
                            hour_bcd, min_bcd, sec_bcd, pm, day_pulse, exp_hour(0));
      end
      step(0, 0, 0, 5'd0);
      n_checks++;
      if ({day_pulse, sec_bcd} !== 9'h000) begin
         n_fail++; $display("FAIL midnight_post: dp=%b sec=%h want dp=0 sec=00", day_pulse, sec_bcd);
      end
   endtask

   task automatic test_set_walk();
      logic expect_on;
      step(1, 0, 0, 5'd0);
      step(0, 0, 0, 5'b00001);
      n_checks++;
      if ({set_mode, set_field, field_on} !== 4'b1011) begin
         n_fail++; $display("FAIL walk_enter: got %b want 1011", {set_mode, set_field, field_on});
      end
      step(0, 0, 0, 5'b00100);
      n_checks++;
      if ({hour_bcd, pm} !== {exp_hour(23), exp_pm(23)}) begin
         n_fail++; $display("FAIL walk_hour_wrap: got %h pm=%b want %h", hour_bcd, pm, exp_hour(23));
      end
      step(0, 0, 0, 5'b00001);
      step(0, 0, 0, 5'b00100);
      n_checks++;
      if ({set_field, min_bcd} !== {2'd2, 8'h59}) begin
         n_fail++; $display("FAIL walk_min_dn: got f=%0d min=%h want f=2 min=59", set_field, min_bcd);
      end
      step(0, 0, 0, 5'b00010);
      n_checks++;
      if ({hour_bcd, min_bcd, day_pulse} !== {exp_hour(23), 8'h00, 1'b0}) begin
         n_fail++; $display("FAIL walk_min_wrap: got %h:%h dp=%b want %h:00 dp=0", hour_bcd, min_bcd, day_pulse, exp_hour(23));
      end
      step(0, 0, 0, 5'b00001);
      expect_on = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 5'd0);
         expect_on = ~expect_on;
         n_checks++;
         if ({sec_bcd, field_on, set_field} !== {8'h00, expect_on, 2'd3}) begin
            n_fail++; $display("FAIL walk_freeze[%0d]: got sec=%h on=%b f=%0d want sec=00 on=%b f=3",
                               i, sec_bcd, field_on, set_field, expect_on);
         end
      end
      step(0, 0, 0, 5'b00001);
      step(0, 0, 0, 5'b00110);
      n_checks++;
      if ({set_mode, field_on, min_bcd, sec_bcd} !== {2'b01, 16'h0000}) begin
         n_fail++; $display("FAIL walk_run_keys: got mode=%b on=%b %h:%h", set_mode, field_on, min_bcd, sec_bcd);
      end
   endtask

   task automatic test_timeout();
      step(1, 0, 0, 5'd0);
      step(0, 0, 0, 5'b00001);
      step(0, 0, 0, 5'b00001);
      step(0, 0, 0, 5'b00010);
      step(0, 1, 0, 5'd0);
      n_checks++;
      if ({set_field, min_bcd, field_on} !== {2'd2, 8'h01, 1'b0}) begin
         n_fail++; $display("FAIL timeout_setup: got f=%0d min=%h on=%b", set_field, min_bcd, field_on);
      end
      step(0, 0, 1, 5'b00010);
      n_checks++;
      if ({set_mode, set_field, field_on, min_bcd} !== {4'b0001, 8'h01}) begin
         n_fail++; $display("FAIL timeout_exit: got mode=%b f=%0d on=%b min=%h want 0 0 1 01",
                            set_mode, set_field, field_on, min_bcd);
      end
      step(0, 1, 0, 5'd0);
      n_checks++;
      if (sec_bcd !== 8'h01) begin
         n_fail++; $display("FAIL timeout_tick: got sec=%h want 01", sec_bcd);
      end
   endtask

   task automatic test_simultaneous();
      step(1, 0, 0, 5'd0);
      set_time(0, 0, 59);
      step(0, 1, 0, 5'b10000);
      n_checks++;
      if ({min_bcd, sec_bcd} !== 16'h0000) begin
         n_fail++; $display("FAIL clr_vs_tick: got %h:%h want 00:00", min_bcd, sec_bcd);
      end
      step(0, 1, 0, 5'b00001);
      n_checks++;
      if ({sec_bcd, set_mode, set_field} !== {8'h01, 1'b1, 2'd1}) begin
         n_fail++; $display("FAIL mode_vs_tick: got sec=%h mode=%b f=%0d want 01 1 1", sec_bcd, set_mode, set_field);
      end
      step(0, 0, 1, 5'd0);
   endtask

   task automatic test_hour_mode();
      step(1, 0, 0, 5'd0);
      set_time(13, 0, 0);
      n_checks++;
      if ({hour_bcd, pm} !== {exp_hour(13), exp_pm(13)}) begin
         n_fail++; $display("FAIL hour_13: got %h pm=%b want %h pm=%b", hour_bcd, pm, exp_hour(13), exp_pm(13));
      end
`ifdef TIME_12H_EN
      step(1, 0, 0, 5'd0);
      set_time(23, 59, 59);
      n_checks++;
      if ({hour_bcd, pm} !== {8'h11, 1'b1}) begin
         n_fail++; $display("FAIL h12_preload: got %h pm=%b want 11 pm=1", hour_bcd, pm);
      end
      step(0, 1, 0, 5'd0);
      n_checks++;
      if ({hour_bcd, min_bcd, sec_bcd, pm, day_pulse} !== {24'h120000, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL h12_midnight: got %h%h%h pm=%b dp=%b want 120000 pm=0 dp=1",
                            hour_bcd, min_bcd, sec_bcd, pm, day_pulse);
      end
`endif
   endtask

   task automatic test_random();
      bit r, t, to;
      logic [4:0] k;
      step(1, 0, 0, 5'd0);
      for (int i = 0; i < 4000; i++) begin
         r  = ($urandom_range(0, 499) == 0);
         t  = ($urandom_range(0, 2) == 0);
         to = ($urandom_range(0, 29) == 0);
         k  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
         step(r, t, to, k);
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL random[%0d] in r=%b t=%b to=%b k=%b: got %h want %h",
                     i, r, t, to, k, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_minute();
      test_midnight();
      test_set_walk();
      test_timeout();
      test_simultaneous();
      test_hour_mode();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
